// File: rtl/vga_pkg.sv
// vga_pkg: axis segment type, default 640x480@60 timing and MSB-first colour expansion.
package vga_pkg;
    typedef enum logic [1:0] {SEG_ACT, SEG_FP, SEG_SYN, SEG_BP} seg_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_PULSE  = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_PULSE  = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int EXP_MAX      = 32;

    // Repeats the in_w-bit field MSB-first until out_w bits are filled; result is right-aligned.
    function automatic logic [EXP_MAX-1:0] expand(input logic [EXP_MAX-1:0] field, input int in_w,
                                                  input int out_w);
        logic [EXP_MAX-1:0] res;
        res = '0;
        for (int i = 0; i < EXP_MAX; i++)
            if (i < out_w)
                res = {res[EXP_MAX-2:0], 1'(field >> (in_w - 1 - i % in_w))};
        return res;
    endfunction
endpackage

// File: rtl/vga_axis_fsm.sv
// vga_axis_fsm: one timing axis, a segment counter walking ACT -> FP -> SYN -> BP.
module vga_axis_fsm import vga_pkg::*; #(
    parameter int ACT = 640,
    parameter int FP  = 16,
    parameter int SYN = 96,
    parameter int BP  = 48,
    parameter int CW  = 10
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          adv_en,
    output seg_t          seg,
    output logic [CW-1:0] count,
    output logic          wrap
);
    logic [CW-1:0] last;
    logic          seg_end;

    always_comb
        last = seg == SEG_ACT ? CW'(ACT - 1) :
               seg == SEG_FP  ? CW'(FP - 1)  :
               seg == SEG_SYN ? CW'(SYN - 1) : CW'(BP - 1);

    assign seg_end = adv_en && count == last;
    assign wrap    = seg_end && seg == SEG_BP;

    // BP + 1 wraps to ACT through the 2-bit encoding
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            seg   <= SEG_ACT;
            count <= '0;
        end else if (seg_end) begin
            seg   <= seg_t'(seg + 2'd1);
            count <= '0;
        end else if (adv_en) begin
            count <= count + 1'b1;
        end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/blank generator with colour expansion and strobes.
// Optional VGA_TESTPAT_EN adds test_en, which replaces color_in with 8 vertical colour bars.
module vga_timing_gen import vga_pkg::*; #(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_PULSE   = DEF_H_PULSE,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_PULSE   = DEF_V_PULSE,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int R_W       = 3,
    parameter int G_W       = 3,
    parameter int B_W       = 2,
    parameter int OUT_W     = 8,
    parameter int CW        = 10
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [R_W+G_W+B_W-1:0] color_in,
`ifdef VGA_TESTPAT_EN
    input  logic                   test_en,
`endif
    output logic [CW-1:0]          next_x,
    output logic [CW-1:0]          next_y,
    output logic                   pixel_req,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   blank_n,
    output logic [OUT_W-1:0]       red,
    output logic [OUT_W-1:0]       green,
    output logic [OUT_W-1:0]       blue,
    output logic                   sync_n,
    output logic                   vga_clk,
    output logic                   frame_start,
    output logic                   line_start
);
    localparam int PW = R_W + G_W + B_W;

    seg_t             h_seg, v_seg;
    logic [CW-1:0]    h_count, v_count;
    logic             h_wrap, unused_v_wrap;
    logic [OUT_W-1:0] r_px, g_px, b_px, r_exp, g_exp, b_exp;

    vga_axis_fsm #(.ACT(H_ACTIVE), .FP(H_FRONT), .SYN(H_PULSE), .BP(H_BACK), .CW(CW)) u_h (
        .clock(clock), .reset_n(reset_n), .adv_en(1'b1),
        .seg(h_seg), .count(h_count), .wrap(h_wrap)
    );

    vga_axis_fsm #(.ACT(V_ACTIVE), .FP(V_FRONT), .SYN(V_PULSE), .BP(V_BACK), .CW(CW)) u_v (
        .clock(clock), .reset_n(reset_n), .adv_en(h_wrap),
        .seg(v_seg), .count(v_count), .wrap(unused_v_wrap)
    );

    assign pixel_req = h_seg == SEG_ACT && v_seg == SEG_ACT;
    assign next_x    = h_seg == SEG_ACT ? h_count : '0;
    assign next_y    = v_seg == SEG_ACT ? v_count : '0;
    assign sync_n    = 1'b0;
    assign vga_clk   = clock;

    always_comb begin
        r_exp = OUT_W'(expand(EXP_MAX'(color_in[PW-1 -: R_W]), R_W, OUT_W));
        g_exp = OUT_W'(expand(EXP_MAX'(color_in[G_W+B_W-1 -: G_W]), G_W, OUT_W));
        b_exp = OUT_W'(expand(EXP_MAX'(color_in[B_W-1:0]), B_W, OUT_W));
    end

`ifdef VGA_TESTPAT_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [CW-1:0] bar_pos;
    logic [2:0]    bar_idx;

    // The last bar holds its index so it absorbs any remainder of H_ACTIVE/8
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (h_seg != SEG_ACT) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (bar_idx != 3'd7) begin
            if (bar_pos == CW'(BAR_W - 1)) begin
                bar_pos <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pos <= bar_pos + 1'b1;
            end
        end

    // Bars: white, yellow, cyan, green, magenta, red, blue, black
    always_comb begin
        r_px = test_en ? {OUT_W{~bar_idx[1]}} : r_exp;
        g_px = test_en ? {OUT_W{~bar_idx[2]}} : g_exp;
        b_px = test_en ? {OUT_W{~bar_idx[0]}} : b_exp;
    end
`else
    always_comb begin
        r_px = r_exp;
        g_px = g_exp;
        b_px = b_exp;
    end
`endif

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            blank_n     <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hsync       <= h_seg == SEG_SYN ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= v_seg == SEG_SYN ? VSYNC_POL : ~VSYNC_POL;
            blank_n     <= pixel_req;
            red         <= pixel_req ? r_px : '0;
            green       <= pixel_req ? g_px : '0;
            blue        <= pixel_req ? b_px : '0;
            frame_start <= pixel_req && next_x == '0 && next_y == '0;
            line_start  <= pixel_req && next_x == '0;
        end
endmodule
